// File: rtl/switch_pkg.sv
// Shared types and constants for the slide-switch / key PIO conditioning blocks.
package switch_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
   localparam int COUNT_W                 = 8;

   typedef enum logic [1:0] {
      STABLE_LO  = 2'd0,
      CONFIRM_HI = 2'd1,
      STABLE_HI  = 2'd2,
      CONFIRM_LO = 2'd3
   } state_t;

endpackage

// File: rtl/switch_sync.sv
// Multi-flop synchroniser for an asynchronous pad; only the last stage is exported.
module switch_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (!reset_n) chain <= {SYNC_STAGES{RESET_LEVEL}};
      else          chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Debounces one slide switch for the Nios PIO in_port and reports edges, toggles,
// committed presses and aborted confirmations.
module switch_debounce import switch_pkg::*; #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 16,
   parameter bit RESET_LEVEL     = 1'b0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sw_raw,
   input  logic               stats_clr,
   output logic               sw_clean,
   output logic               rise_pulse,
   output logic               fall_pulse,
   output logic               toggle_state,
   output logic [COUNT_W-1:0] press_count,
   output logic [COUNT_W-1:0] bounce_count
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("switch_debounce: SYNC_STAGES must be 2..4");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
      $error("switch_debounce: DEBOUNCE_CYCLES must be >= 2");
   end
   if (CNT_W < 1 || CNT_W > 30 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt
      $error("switch_debounce: CNT_W too small for DEBOUNCE_CYCLES");
   end

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam state_t           RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   logic             sw_sync;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             at_last, abort, commit_rise, commit_fall;

   switch_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_LEVEL(RESET_LEVEL)
   ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (sw_raw),
      .q      (sw_sync)
   );

   // The input reverting while a change is being confirmed counts as a bounce.
   assign at_last     = (cnt == CNT_LAST);
   assign abort       = (state == CONFIRM_HI && !sw_sync) || (state == CONFIRM_LO && sw_sync);
   assign commit_rise = (state == CONFIRM_HI) && sw_sync && at_last;
   assign commit_fall = (state == CONFIRM_LO) && !sw_sync && at_last;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= RESET_STATE;
         cnt          <= '0;
         sw_clean     <= RESET_LEVEL;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         toggle_state <= 1'b0;
      end else begin
         rise_pulse <= commit_rise;
         fall_pulse <= commit_fall;
         case (state)
            STABLE_LO:
               if (sw_sync) begin
                  state <= CONFIRM_HI;
                  cnt   <= CNT_W'(1);
               end
            CONFIRM_HI:
               if (abort) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else if (commit_rise) begin
                  state        <= STABLE_HI;
                  cnt          <= '0;
                  sw_clean     <= 1'b1;
                  toggle_state <= ~toggle_state;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            STABLE_HI:
               if (!sw_sync) begin
                  state <= CONFIRM_LO;
                  cnt   <= CNT_W'(1);
               end
            CONFIRM_LO:
               if (abort) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else if (commit_fall) begin
                  state    <= STABLE_LO;
                  cnt      <= '0;
                  sw_clean <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
         endcase
      end
   end

   // A clear wins over an increment landing on the same edge.
   always_ff @(posedge clk) begin
      if (!reset_n || stats_clr) begin
         press_count  <= '0;
         bounce_count <= '0;
      end else begin
         if (commit_rise)                 press_count  <= press_count + COUNT_W'(1);
         if (abort && bounce_count != '1) bounce_count <= bounce_count + COUNT_W'(1);
      end
   end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditions one raw mechanical slide switch before it reaches the Nios PIO input port that samples `in_port`. That PIO is a 1-bit Avalon slave at address 0.
- Synchronises the asynchronous pad, rejects contact bounce with a confirm counter, and drives a stable level into the PIO.
- Also produces single-cycle edge pulses plus toggle, press and bounce statistics for the SOPC/Qsys top level and for debug.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the metastability chain; legal range 2..4.
- DEBOUNCE_CYCLES, 50000, consecutive cycles the synchronised input must differ from `sw_clean` before commit; minimum 2. The default is 1 ms at 50 MHz.
- CNT_W, 16, confirm-counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- RESET_LEVEL, 0, level assumed for the switch, sync chain and `sw_clean` at reset.

Ports:
- clk, input, 1, system clock, the same clock as the Nios PIO.
- reset_n, input, 1, reset, active-low.
- sw_raw, input, 1, asynchronous switch pad.
- stats_clr, input, 1, synchronous clear of `press_count` and `bounce_count`.
- sw_clean, output, 1, debounced level; connects to the PIO `in_port`.
- rise_pulse, output, 1, one-cycle pulse on a committed 0->1 change.
- fall_pulse, output, 1, one-cycle pulse on a committed 1->0 change.
- toggle_state, output, 1, inverts on every committed rise.
- press_count, output, 8, committed rises, wrapping.
- bounce_count, output, 8, aborted confirmations, saturating at 255.

Behaviour:
- Interface: one clock, `clk`. Reset `reset_n` is synchronous and active-low.
- Reset values: sync chain = RESET_LEVEL; `sw_clean` = RESET_LEVEL; `rise_pulse`, `fall_pulse`, `toggle_state` = 0; counts = 0; confirm counter = 0; FSM = STABLE_LO if RESET_LEVEL = 0, else STABLE_HI.
- Reset asserted mid-confirmation discards the pending change. No pulse is emitted.
- Sync chain: `sw_sync` is the last stage, `SYNC_STAGES` edges after `sw_raw` is sampled. Nothing downstream uses the earlier stages.
- FSM states and transitions:
  - STABLE_LO: if `sw_sync` = 1 -> CONFIRM_HI, counter = 1.
  - CONFIRM_HI:
    - `sw_sync` = 0 -> STABLE_LO, counter = 0, `bounce_count` += 1 (saturating).
    - `sw_sync` = 1 and counter = DEBOUNCE_CYCLES-1 -> STABLE_HI, `sw_clean` <= 1, `rise_pulse` <= 1, `toggle_state` inverts, `press_count` += 1 (mod 256), counter = 0.
    - Otherwise counter += 1.
  - STABLE_HI / CONFIRM_LO: mirror image. A commit sets `sw_clean` <= 0 and `fall_pulse` <= 1, with no count change.
- Latency: if `sw_sync` first differs from `sw_clean` after edge n and holds, `sw_clean` changes at edge n + DEBOUNCE_CYCLES.
- Total raw-to-clean latency is SYNC_STAGES + DEBOUNCE_CYCLES edges.
- A glitch lasting DEBOUNCE_CYCLES-1 cycles or fewer never reaches `sw_clean`.
- Pulses are registered and high for exactly the one cycle in which `sw_clean` first shows its new level. Pulses are never back-to-back, because the minimum commit spacing is DEBOUNCE_CYCLES.
- `stats_clr` takes priority over a same-cycle increment: both counts read 0 next cycle. `stats_clr` does not affect `sw_clean`, the FSM or `toggle_state`.
- Abort and commit cannot occur in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The counter never exceeds DEBOUNCE_CYCLES-1.
- Illegal parameters (DEBOUNCE_CYCLES < 2, CNT_W too small, SYNC_STAGES < 2) stop elaboration with an `$error` in a generate check.

Decomposition:
- Shared package `switch_pkg`:
  - FSM state typedef (2-bit): STABLE_LO = 0, CONFIRM_HI = 1, STABLE_HI = 2, CONFIRM_LO = 3.
  - Constant DEFAULT_DEBOUNCE_CYCLES = 50000.
  - Constant COUNT_W = 8.
- One natural sub-module, `switch_sync`: a parameterised SYNC_STAGES flip-flop chain with reset value RESET_LEVEL. The chain is reusable for the key/button PIO inputs.
- The FSM, confirm counter and statistics stay in `switch_debounce`.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0):
1. Reset: hold `reset_n` = 0 for 3 edges with `sw_raw` = 1 -> all outputs 0. After release, `sw_clean` rises 6 edges later.
2. Clean press: `sw_raw` 0->1 sampled at edge 0 and held -> `sw_clean` = 1 and `rise_pulse` = 1 from edge 6 for one cycle; `toggle_state` = 1; `press_count` = 1; `bounce_count` = 0.
3. Bounce: `sw_raw` high for 3 cycles then low -> `sw_clean` stays 0, no pulse, `bounce_count` = 1. Five such bursts, then a steady high -> `bounce_count` = 5, `press_count` = 1.
4. Release: from `sw_clean` = 1, `sw_raw` -> 0 held -> `fall_pulse` for one cycle at edge 6; `toggle_state` unchanged; `press_count` unchanged.
5. Reset mid-confirm: `sw_raw` rises; `reset_n` = 0 at edge 4 for one cycle -> no pulse, `sw_clean` = 0. With `sw_raw` still high, `sw_clean` commits 6 edges after release (sync refill + 4).
6. Wrap, saturation and clear:
   - 256 clean presses -> `press_count` = 0, `toggle_state` = 0.
   - 300 bounces -> `bounce_count` = 255.
   - `stats_clr` asserted on the commit edge of a press -> both counts = 0 and `sw_clean` = 1.
